div_clk_ctrl: RTL

Run/stop and ratio controller for the divided clock derived from CLK_IN. It owns the divide counter and sequences start, stop and ratio changes. CLK_OUT therefore never shows a runt phase. New ratios arrive over a valid/ready handshake and are applied only at a period boundary.

---
 rtl/div_clk_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/div_clk_ctrl.sv
// Run/stop and ratio controller for a divided clock with glitch-free start/stop.
// Optional DIV_CLK_CTRL_TICK_EN adds a registered tick_out_o pulse on every rising clk_out_o.
module div_clk_ctrl #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_HALF = 4
) (
  input  logic             clk_in_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cfg_half_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             clk_out_o,
  output logic             running_o,
  output logic [1:0]       state_o
`ifdef DIV_CLK_CTRL_TICK_EN
  ,
  output logic             tick_out_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] half_act_q, half_act_d;
  logic [WIDTH-1:0] half_pend_q, half_pend_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             accept, term, boundary, to_idle;
  logic [WIDTH-1:0] cfg_val;

  // Handshake: a config transfers on any edge where cfg_valid_i && cfg_ready_o.
  assign accept   = cfg_valid_i && !pend_q;
  assign cfg_val  = (cfg_half_i == '0) ? WIDTH'(1) : cfg_half_i;
  assign term     = (cnt_q == half_act_q - WIDTH'(1));
  assign boundary = term && clk_q;

  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      half_act_q  <= WIDTH'(DEFAULT_HALF);
      half_pend_q <= '0;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_act_q  <= half_act_d;
      half_pend_q <= half_pend_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_d       = clk_q;
    half_act_d  = half_act_q;
    half_pend_d = half_pend_q;
    pend_d      = pend_q;
    to_idle     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (accept) half_act_d = cfg_val;
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end
      end
      RUN, STOP: begin
        // Stop only from a low level or at the falling edge, so no phase is cut short.
        if (!en_i && (!clk_q || boundary)) to_idle = 1'b1;
        else state_d = en_i ? RUN : STOP;
        if (term) begin
          cnt_d = '0;
          clk_d = ~clk_q;
          if (boundary && pend_q) begin
            half_act_d = half_pend_q;
            pend_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        if (accept) begin
          half_pend_d = cfg_val;
          pend_d      = 1'b1;
        end
        if (to_idle) begin
          state_d = IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          pend_d  = 1'b0;
          if (accept)      half_act_d = cfg_val;
          else if (pend_q) half_act_d = half_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready_o = !pend_q;
  assign clk_out_o   = clk_q;
  assign running_o   = (state_q != IDLE);
  assign state_o     = state_q;

`ifdef DIV_CLK_CTRL_TICK_EN
  logic tick_q;
  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) tick_q <= 1'b0;
    else          tick_q <= clk_d && !clk_q;
  end
  assign tick_out_o = tick_q;
`endif

endmodule
